motor_startup_scheduler: RTL and testbench



---
 rtl/motor_startup_scheduler_pkg.sv | 20 ++
 rtl/motor_startup_scheduler_rr_arbiter.sv | 31 +++
 rtl/motor_startup_scheduler.sv | 171 +++++++++++++++++
 tb/tb_motor_startup_scheduler.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/motor_startup_scheduler_pkg.sv
// Shared types for the motor startup scheduler: per-motor state encodings
// and the width helper used to size indices, timers and counters.
package motor_startup_scheduler_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WAIT    = 3'd1,
      ST_START   = 3'd2,
      ST_RUN     = 3'd3,
      ST_FRST    = 3'd4,
      ST_BACKOFF = 3'd5,
      ST_DEAD    = 3'd6
   } motor_state_e;

   // Bits needed to hold 0..v-1, never less than one.
   function automatic int log2c(input int v);
      return (v <= 2) ? 1 : $clog2(v);
   endfunction

endpackage

// File: rtl/motor_startup_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter for the startup slot.
// Ports: req (per motor), ptr (search start) -> gnt (one-hot), gnt_idx, gnt_vld.
module rr_arbiter #(
   parameter int N    = 5,
   parameter int IDXW = 3
) (
   input  logic [N-1:0]    req,
   input  logic [IDXW-1:0] ptr,
   output logic [N-1:0]    gnt,
   output logic [IDXW-1:0] gnt_idx,
   output logic            gnt_vld
);

   logic [IDXW-1:0] j;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      gnt_vld = 1'b0;
      j       = ptr;
      for (int k = 0; k < N; k++) begin
         if (!gnt_vld && req[j]) begin
            gnt_vld = 1'b1;
            gnt[j]  = 1'b1;
            gnt_idx = j;
         end
         j = (j == IDXW'(N - 1)) ? '0 : j + IDXW'(1);
      end
   end

endmodule

// File: rtl/motor_startup_scheduler.sv
// Staggers BLDC driver startups through one shared slot, retries faulted
// drivers after a backoff and latches motors that keep faulting.
// Ports: clk, rst_n, global_en, clear_faults, cmd_duty, drv_fault in;
//        drv_en, drv_duty, motor_dead, slot_busy, slot_owner out (all registered).
module motor_startup_scheduler
   import motor_startup_scheduler_pkg::*;
#(
   parameter int NUM_MOTORS           = 5,
   parameter int DUTY_CYCLE_WIDTH     = 10,
   parameter int MIN_DUTY_CYCLE       = 0,
   parameter int STARTUP_HOLD_CYCLES  = 16384,
   parameter int RETRY_BACKOFF_CYCLES = 65536,
   parameter int FAULT_RETRY_MAX      = 3
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic                                   global_en,
   input  logic                                   clear_faults,
   input  logic [NUM_MOTORS*DUTY_CYCLE_WIDTH-1:0] cmd_duty,
   input  logic [NUM_MOTORS-1:0]                  drv_fault,
   output logic [NUM_MOTORS-1:0]                  drv_en,
   output logic [NUM_MOTORS*DUTY_CYCLE_WIDTH-1:0] drv_duty,
   output logic [NUM_MOTORS-1:0]                  motor_dead,
   output logic                                   slot_busy,
   output logic [log2c(NUM_MOTORS)-1:0]           slot_owner
);

   localparam int W  = DUTY_CYCLE_WIDTH;
   localparam int IW = log2c(NUM_MOTORS);
   localparam int TW = log2c(STARTUP_HOLD_CYCLES);
   localparam int BW = log2c(RETRY_BACKOFF_CYCLES);
   localparam int RW = log2c(FAULT_RETRY_MAX + 1);

   logic [NUM_MOTORS-1:0] req, gnt, starting_d;
   logic [IW-1:0]         gnt_idx;
   logic                  gnt_vld;

   logic          slot_busy_q, slot_busy_d;
   logic [IW-1:0] slot_owner_q, slot_owner_d;
   logic [IW-1:0] ptr_q, ptr_d;
   logic [TW-1:0] slot_tmr_q, slot_tmr_d;

   rr_arbiter #(
      .N    (NUM_MOTORS),
      .IDXW (IW)
   ) u_arb (
      .req     (req),
      .ptr     (ptr_q),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .gnt_vld (gnt_vld)
   );

   // Slot stays held only while its owner remains in STARTING; any other
   // exit (timeout, cancel, fault, disable) frees it at the same edge.
   always_comb begin
      slot_busy_d  = slot_busy_q ? starting_d[slot_owner_q] : gnt_vld;
      slot_owner_d = gnt_vld ? gnt_idx : slot_owner_q;
      slot_tmr_d   = slot_tmr_q;
      ptr_d        = ptr_q;
      if (gnt_vld) begin
         slot_tmr_d = TW'(STARTUP_HOLD_CYCLES - 1);
         ptr_d      = (gnt_idx == IW'(NUM_MOTORS - 1)) ? '0 : gnt_idx + IW'(1);
      end else if (slot_busy_q && slot_tmr_q != '0) begin
         slot_tmr_d = slot_tmr_q - TW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_busy_q  <= 1'b0;
         slot_owner_q <= '0;
         ptr_q        <= '0;
         slot_tmr_q   <= '0;
      end else begin
         slot_busy_q  <= slot_busy_d;
         slot_owner_q <= slot_owner_d;
         ptr_q        <= ptr_d;
         slot_tmr_q   <= slot_tmr_d;
      end
   end

   assign slot_busy  = slot_busy_q;
   assign slot_owner = slot_owner_q;

   for (genvar i = 0; i < NUM_MOTORS; i++) begin : g_motor
      motor_state_e  state_q, state_d;
      logic [RW-1:0] retry_q, retry_d, retry_inc;
      logic [BW-1:0] bo_q, bo_d;
      logic [W-1:0]  cmd, duty_q, duty_d;
      logic          cmd_on, en_q, en_d, dead_q, dead_d;

      assign cmd       = cmd_duty[i*W +: W];
      assign cmd_on    = cmd > W'(MIN_DUTY_CYCLE);
      assign retry_inc = (retry_q == '1) ? retry_q : retry_q + RW'(1);

      // Only a waiter that will stay put this cycle may win the slot.
      assign req[i] = !slot_busy_q && global_en && cmd_on &&
                      !drv_fault[i] && (state_q == ST_WAIT);

      always_comb begin
         state_d = state_q;
         retry_d = clear_faults ? '0 : retry_q;
         bo_d    = bo_q;
         if (state_q == ST_DEAD) begin
            if (clear_faults) state_d = ST_IDLE;
         end else if (!global_en) begin
            state_d = ST_IDLE;
         end else begin
            unique case (state_q)
               ST_IDLE: if (cmd_on) state_d = ST_WAIT;
               ST_WAIT: begin
                  if (drv_fault[i])  state_d = ST_FRST;
                  else if (!cmd_on)  state_d = ST_IDLE;
                  else if (gnt[i])   state_d = ST_START;
               end
               ST_START: begin
                  if (drv_fault[i])             state_d = ST_FRST;
                  else if (!cmd_on)             state_d = ST_IDLE;
                  else if (slot_tmr_q == '0)    state_d = ST_RUN;
               end
               ST_RUN: begin
                  if (drv_fault[i])  state_d = ST_FRST;
                  else if (!cmd_on)  state_d = ST_IDLE;
               end
               ST_FRST: begin
                  if (!clear_faults) retry_d = retry_inc;
                  if (!clear_faults && retry_inc == RW'(FAULT_RETRY_MAX)) begin
                     state_d = ST_DEAD;
                  end else begin
                     state_d = ST_BACKOFF;
                     bo_d    = BW'(RETRY_BACKOFF_CYCLES - 1);
                  end
               end
               ST_BACKOFF: begin
                  if (bo_q == '0) state_d = ST_IDLE;
                  else            bo_d    = bo_q - BW'(1);
               end
               default: state_d = ST_IDLE;
            endcase
         end
         en_d   = state_d inside {ST_WAIT, ST_START, ST_RUN};
         duty_d = (state_d inside {ST_START, ST_RUN}) ? cmd : '0;
         dead_d = (state_d == ST_DEAD);
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            state_q <= ST_IDLE;
            retry_q <= '0;
            bo_q    <= '0;
            en_q    <= 1'b0;
            duty_q  <= '0;
            dead_q  <= 1'b0;
         end else begin
            state_q <= state_d;
            retry_q <= retry_d;
            bo_q    <= bo_d;
            en_q    <= en_d;
            duty_q  <= duty_d;
            dead_q  <= dead_d;
         end
      end

      assign starting_d[i]       = (state_d == ST_START);
      assign drv_en[i]           = en_q;
      assign drv_duty[i*W +: W]  = duty_q;
      assign motor_dead[i]       = dead_q;
   end

endmodule

// File: tb/tb_motor_startup_scheduler.sv
// Directed bench for motor_startup_scheduler with short hold/backoff times.
// Checks staggering, cancel, fault retry/dead latch, global disable, async reset.
module tb_motor_startup_scheduler;

   localparam int N  = 5;
   localparam int W  = 10;
   localparam int H  = 16;
   localparam int BO = 32;

   logic           clk = 1'b0;
   logic           rst_n, global_en, clear_faults;
   logic [N*W-1:0] cmd_duty;
   logic [N-1:0]   drv_fault;
   logic [N-1:0]   drv_en;
   logic [N*W-1:0] drv_duty;
   logic [N-1:0]   motor_dead;
   logic           slot_busy;
   logic [2:0]     slot_owner;

   int total = 0;
   int bad   = 0;

   motor_startup_scheduler #(
      .NUM_MOTORS           (N),
      .DUTY_CYCLE_WIDTH     (W),
      .MIN_DUTY_CYCLE       (0),
      .STARTUP_HOLD_CYCLES  (H),
      .RETRY_BACKOFF_CYCLES (BO),
      .FAULT_RETRY_MAX      (3)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .global_en    (global_en),
      .clear_faults (clear_faults),
      .cmd_duty     (cmd_duty),
      .drv_fault    (drv_fault),
      .drv_en       (drv_en),
      .drv_duty     (drv_duty),
      .motor_dead   (motor_dead),
      .slot_busy    (slot_busy),
      .slot_owner   (slot_owner)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic set_cmd(input int i, input int v);
      cmd_duty[i*W +: W] = W'(v);
   endtask

   function automatic logic [N*W-1:0] dv(input int a, input int b,
                                         input int c, input int d,
                                         input int e);
      return {W'(e), W'(d), W'(c), W'(b), W'(a)};
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n        = 1'b0;
      global_en    = 1'b0;
      clear_faults = 1'b0;
      cmd_duty     = '0;
      drv_fault    = '0;
      tick(3);
      chk("rst_en",    drv_en, 0);
      chk("rst_duty",  drv_duty, 0);
      chk("rst_dead",  motor_dead, 0);
      chk("rst_busy",  slot_busy, 0);
      chk("rst_owner", slot_owner, 0);
      rst_n = 1'b1;
      tick(1);

      // staggered start
      global_en = 1'b1;
      for (int i = 0; i < N; i++) set_cmd(i, 300);
      tick(1);
      chk("wait_en",   drv_en, 5'h1f);
      chk("wait_duty", drv_duty, 0);
      chk("wait_busy", slot_busy, 0);
      tick(1);
      chk("g0_busy",  slot_busy, 1);
      chk("g0_owner", slot_owner, 0);
      chk("g0_duty",  drv_duty, dv(300, 0, 0, 0, 0));
      tick(H - 1);
      chk("g0_hold",  slot_busy, 1);
      tick(1);
      chk("g0_rel",   slot_busy, 0);
      chk("g0_run",   drv_duty, dv(300, 0, 0, 0, 0));
      for (int k = 1; k < N; k++) begin
         tick(1);
         chk("gk_owner", slot_owner, k);
         chk("gk_busy",  slot_busy, 1);
         tick(H);
         chk("gk_rel",   slot_busy, 0);
         chk("gk_duty",  drv_duty[k*W +: W], 300);
      end
      chk("all_duty", drv_duty, dv(300, 300, 300, 300, 300));
      chk("all_en",   drv_en, 5'h1f);

      // cancel during startup
      set_cmd(2, 0);
      set_cmd(3, 0);
      tick(1);
      chk("c_idle_en", drv_en, 5'b10011);
      set_cmd(2, 300);
      set_cmd(3, 300);
      tick(1);
      chk("c_wait_en", drv_en, 5'h1f);
      tick(1);
      chk("c_g2_owner", slot_owner, 2);
      chk("c_g2_busy",  slot_busy, 1);
      tick(3);
      set_cmd(2, 0);
      tick(1);
      chk("c_en2",   drv_en[2], 0);
      chk("c_duty2", drv_duty[2*W +: W], 0);
      chk("c_rel",   slot_busy, 0);
      chk("c_en3",   drv_en[3], 1);
      tick(1);
      chk("c_g3_owner", slot_owner, 3);
      chk("c_g3_busy",  slot_busy, 1);
      set_cmd(3, 500);
      tick(1);
      chk("c_pass_duty", drv_duty[3*W +: W], 500);
      chk("c_pass_busy", slot_busy, 1);
      tick(H - 1);
      chk("c_g3_rel",  slot_busy, 0);
      chk("c_g3_duty", drv_duty[3*W +: W], 500);

      // fault 1 in RUNNING
      drv_fault[1] = 1'b1;
      tick(1);
      drv_fault[1] = 1'b0;
      chk("f1_en",   drv_en[1], 0);
      chk("f1_duty", drv_duty[W +: W], 0);
      chk("f1_dead", motor_dead, 0);
      tick(BO + 1);
      chk("f1_idle", drv_en[1], 0);
      tick(1);
      chk("f1_wait", drv_en[1], 1);
      chk("f1_free", slot_busy, 0);
      tick(1);
      chk("f1_gnt",  slot_owner, 1);
      chk("f1_busy", slot_busy, 1);

      // fault 2 in STARTING releases the slot
      drv_fault[1] = 1'b1;
      tick(1);
      drv_fault[1] = 1'b0;
      chk("f2_en",  drv_en[1], 0);
      chk("f2_rel", slot_busy, 0);
      tick(BO + 1);
      chk("f2_idle", drv_en[1], 0);
      tick(1);
      chk("f2_wait", drv_en[1], 1);
      tick(1);
      chk("f2_gnt",  slot_owner, 1);
      chk("f2_busy", slot_busy, 1);
      tick(H);
      chk("f2_run_busy", slot_busy, 0);
      chk("f2_run_duty", drv_duty[W +: W], 300);

      // fault 3 latches DEAD
      drv_fault[1] = 1'b1;
      tick(1);
      drv_fault[1] = 1'b0;
      chk("f3_en",   drv_en[1], 0);
      chk("f3_dead0", motor_dead, 0);
      tick(1);
      chk("f3_dead", motor_dead, 5'b00010);
      tick(40);
      chk("f3_dead_hold", motor_dead, 5'b00010);
      chk("f3_en_hold",   drv_en[1], 0);
      clear_faults = 1'b1;
      tick(1);
      clear_faults = 1'b0;
      chk("clr_dead", motor_dead, 0);
      chk("clr_en",   drv_en[1], 0);
      tick(1);
      chk("clr_wait", drv_en[1], 1);
      tick(1);
      chk("clr_gnt",  slot_owner, 1);
      tick(H);
      chk("clr_run",  slot_busy, 0);

      // global disable mid-start
      cmd_duty = '0;
      tick(1);
      chk("gd_idle", drv_en, 0);
      set_cmd(0, 300);
      tick(2);
      chk("gd_g0_owner", slot_owner, 0);
      chk("gd_g0_busy",  slot_busy, 1);
      set_cmd(1, 300);
      set_cmd(2, 300);
      tick(1);
      chk("gd_wait_en", drv_en, 5'b00111);
      global_en = 1'b0;
      tick(1);
      chk("gd_en",   drv_en, 0);
      chk("gd_busy", slot_busy, 0);
      chk("gd_duty", drv_duty, 0);
      global_en = 1'b1;
      tick(1);
      chk("re_en",   drv_en, 5'b00111);
      chk("re_busy", slot_busy, 0);
      tick(1);
      chk("re_owner", slot_owner, 1);
      chk("re_busy1", slot_busy, 1);

      // async reset mid-BACKOFF with slot busy
      drv_fault[0] = 1'b1;
      tick(1);
      drv_fault[0] = 1'b0;
      chk("ar_f_en", drv_en, 5'b00110);
      tick(1);
      chk("ar_pre_busy", slot_busy, 1);
      rst_n = 1'b0;
      #2;
      chk("ar_en",    drv_en, 0);
      chk("ar_duty",  drv_duty, 0);
      chk("ar_dead",  motor_dead, 0);
      chk("ar_busy",  slot_busy, 0);
      chk("ar_owner", slot_owner, 0);
      tick(2);
      cmd_duty = '0;
      set_cmd(1, 300);
      set_cmd(4, 300);
      rst_n = 1'b1;
      tick(1);
      chk("ar_wait_en", drv_en, 5'b10010);
      chk("ar_wait_busy", slot_busy, 0);
      tick(1);
      chk("ar_ptr_owner", slot_owner, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
